bp_fe_fetch_seq: RTL and testbench
==================================

# bp_fe_fetch_seq

Fetch sequencer for the front end. It owns the fetch PC register and decides, cycle by cycle, whether a fetch is issued to the I-cache/I-TLB. It also handles boot, I-cache miss replay, backend redirects and misaligned-redirect faults. The sequencer sits between the backend command path, the next-PC/prediction datapath and the I-cache request port, and replaces ad-hoc stall logic with an explicit state machine.

## Interface
Parameters:
- eaddr_width_p, 64, effective address width
- bp_first_pc_p, 64'h8000_0000, boot PC

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- redirect_v_i  in  1  backend PC redirect valid
- redirect_pc_i  in  eaddr_width_p  redirect target
- redirect_ready_o  out  1  redirect accepted this cycle when high with redirect_v_i
- next_pc_i  in  eaddr_width_p  next PC from prediction datapath, sampled on issue
- queue_ready_i  in  1  FE queue can take one more fetch
- icache_ready_i  in  1  I-cache accepts a request
- icache_miss_i  in  1  fetch issued previous cycle missed
- fetch_v_o  out  1  fetch request valid
- fetch_pc_o  out  eaddr_width_p  fetch address (PC register)
- fetch_squash_o  out  1  drop the response of the in-flight fetch
- misalign_v_o  out  1  one-cycle pulse: misaligned redirect fault
- miss_cnt_o  out  32  I-cache miss count
- stall_cnt_o  out  32  stalled-cycle count

## Operation
- States: BOOT, RUN, MISS, HALT. The in-flight register holds inflight_pc_r and inflight_v_r.
- issue = fetch_v_o & icache_ready_i.
- fetch_v_o = (state==RUN) & queue_ready_i & ~icache_miss_i & ~redirect_v_i.
- BOOT: fetch_v_o=0 and redirect_ready_o=0. The state moves unconditionally to RUN after one cycle.
- RUN, on issue: pc_r<=next_pc_i, inflight_pc_r<=pc_r, inflight_v_r<=1. Without issue, inflight_v_r<=0.
- RUN with icache_miss_i & inflight_v_r:
  - pc_r<=inflight_pc_r (replay).
  - inflight_v_r<=0.
  - fetch_squash_o=1 that cycle.
  - Next state is MISS.
- icache_miss_i with inflight_v_r=0 is ignored.
- MISS: fetch_v_o=0. The state moves to RUN on the first cycle icache_ready_i=1. The replayed PC issues in the first RUN cycle.
- Redirect: redirect_ready_o=1 in RUN, MISS and HALT. An accepted redirect has priority over the miss and over next_pc_i:
  - pc_r<=redirect_pc_i and inflight_v_r<=0.
  - fetch_squash_o=inflight_v_r.
  - Next state: MISS if (state==MISS | icache_miss_i) & ~icache_ready_i, else RUN.
- Misaligned redirect (redirect_pc_i[1:0]!=0): accepted, pc_r is not updated, misalign_v_o pulses the next cycle, next state is HALT.
- HALT: fetch_v_o=0. The block leaves HALT only on an aligned redirect, which goes to RUN.
- All PC arithmetic is done outside the block. pc_r is a plain eaddr_width_p register with no wrap handling; next_pc_i is taken verbatim.

## Timing
- Reset values (asynchronous, while reset_n_i=0):
  - state=BOOT, pc_r=bp_first_pc_p, inflight_v_r=0.
  - fetch_v_o=0, redirect_ready_o=0, fetch_squash_o=0, misalign_v_o=0.
  - Counters=0.
- Deassertion mid-operation is not special. Reassertion at any point returns the block to BOOT immediately.
- fetch_v_o, redirect_ready_o and fetch_squash_o are combinational from state, registers and the current inputs.
- fetch_pc_o comes straight from pc_r.
- misalign_v_o is registered.
- Redirect-to-issue latency is 1 cycle: redirect accepted in cycle N, fetch_pc_o=target and fetch_v_o can be high in N+1.
- Miss recovery: miss in cycle N puts the block in MISS in N+1. The replay issues in the cycle after icache_ready_i is first seen high in MISS.
- queue_ready_i=0 holds pc_r and keeps fetch_v_o low. No request is lost.

## Configuration
- BP_FE_FETCH_SEQ_PERF_EN defined:
  - miss_cnt_o increments on each accepted miss (the RUN→MISS transition).
  - stall_cnt_o increments each cycle state==RUN & ~fetch_v_o, or state==MISS.
  - Both counters are 32-bit and saturate at 32'hFFFF_FFFF.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset release → fetch_v_o=0 for 1 cycle, then fetch_pc_o=32'h8000_0000 (64-bit), fetch_v_o=1 with queue_ready_i=icache_ready_i=1.
- Issue PC 0x1000 (next 0x1004), icache_miss_i next cycle → fetch_squash_o=1, MISS, fetch_pc_o=0x1000. Hold icache_ready_i=0 for 5 cycles → no issue. Raise it → 0x1000 reissues. miss_cnt_o=1 and stall_cnt_o≥5 with PERF_EN.
- Redirect to 0x2000 in the same cycle as icache_miss_i with icache_ready_i=0 → MISS with pc_r=0x2000, squash=1. 0x2000 issues after icache_ready_i rises.
- Redirect to 0x3002 → misalign_v_o pulses next cycle, HALT, fetch_v_o=0. Redirect to 0x3000 → RUN, fetch 0x3000 one cycle later.
- queue_ready_i=0 for 3 cycles in RUN → fetch_v_o=0 and fetch_pc_o constant. The fetch resumes at the same PC.
- Assert reset_n_i=0 while in MISS → outputs take reset values asynchronously, before the next clk_i edge.

Source files
------------

// File: rtl/bp_fe_fetch_seq.sv
// bp_fe_fetch_seq: front-end fetch sequencer.
// Owns the fetch PC and decides each cycle whether a fetch goes to the
// I-cache/I-TLB. It handles boot, I-cache miss replay, backend redirects
// and misaligned-redirect faults.
// Optional feature macro: BP_FE_FETCH_SEQ_PERF_EN builds the saturating
// miss and stall counters. Without it, miss_cnt_o and stall_cnt_o are tied
// to zero and no counter flops exist.
module bp_fe_fetch_seq #(
  parameter int                       eaddr_width_p = 64,
  parameter logic [eaddr_width_p-1:0] bp_first_pc_p = 64'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     redirect_v_i,
  input  logic [eaddr_width_p-1:0] redirect_pc_i,
  output logic                     redirect_ready_o,
  input  logic [eaddr_width_p-1:0] next_pc_i,
  input  logic                     queue_ready_i,
  input  logic                     icache_ready_i,
  input  logic                     icache_miss_i,
  output logic                     fetch_v_o,
  output logic [eaddr_width_p-1:0] fetch_pc_o,
  output logic                     fetch_squash_o,
  output logic                     misalign_v_o,
  output logic [31:0]              miss_cnt_o,
  output logic [31:0]              stall_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [eaddr_width_p-1:0] pc_q, pc_d;
  logic [eaddr_width_p-1:0] inflight_pc_q, inflight_pc_d;
  logic                     inflight_v_q, inflight_v_d;
  logic                     misalign_q, misalign_d;

  logic redirect_acc;
  logic redirect_misaligned;
  logic miss_acc;
  logic issue;

  // A redirect is taken in every state except BOOT; a miss only counts when
  // the previous cycle actually issued a fetch.
  assign redirect_acc        = redirect_v_i & (state_q != BOOT);
  assign redirect_misaligned = |redirect_pc_i[1:0];
  assign miss_acc            = (state_q == RUN) & icache_miss_i & inflight_v_q;
  assign issue               = fetch_v_o & icache_ready_i;

  // State register, cleared asynchronously to BOOT.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= BOOT;
    else            state_q <= state_d;
  end

  // Next-state logic: accepted redirect beats a miss, which beats issue.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_acc) begin
          if (redirect_misaligned)                    state_d = HALT;
          else if (icache_miss_i & ~icache_ready_i)   state_d = MISS;
          else                                        state_d = RUN;
        end else if (miss_acc) begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (redirect_acc) begin
          if (redirect_misaligned)   state_d = HALT;
          else if (~icache_ready_i)  state_d = MISS;
          else                       state_d = RUN;
        end else if (icache_ready_i) begin
          state_d = RUN;
        end
      end
      HALT: begin
        // Only an aligned redirect clears the fault.
        if (redirect_acc & ~redirect_misaligned) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Combinational request-side outputs.
  always_comb begin
    redirect_ready_o = (state_q != BOOT);
    fetch_v_o        = (state_q == RUN) & queue_ready_i & ~icache_miss_i & ~redirect_v_i;
    fetch_squash_o   = redirect_acc ? inflight_v_q : miss_acc;
  end

  // PC / in-flight next values. A misaligned target is never loaded into the
  // PC; the in-flight tag only survives a cycle that actually issued.
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_v_d  = 1'b0;
    misalign_d    = redirect_acc & redirect_misaligned;
    if (redirect_acc) begin
      if (!redirect_misaligned) pc_d = redirect_pc_i;
    end else if (miss_acc) begin
      pc_d = inflight_pc_q;
    end else if (issue) begin
      pc_d          = next_pc_i;
      inflight_pc_d = pc_q;
      inflight_v_d  = 1'b1;
    end
  end

  // PC, in-flight tag and fault pulse registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q          <= bp_first_pc_p;
      inflight_pc_q <= '0;
      inflight_v_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_v_q  <= inflight_v_d;
      misalign_q    <= misalign_d;
    end
  end

  assign fetch_pc_o   = pc_q;
  assign misalign_v_o = misalign_q;

`ifdef BP_FE_FETCH_SEQ_PERF_EN
  logic [31:0] miss_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        miss_inc;
  logic        stall_inc;

  assign miss_inc  = (state_q == RUN) & (state_d == MISS);
  assign stall_inc = ((state_q == RUN) & ~fetch_v_o) | (state_q == MISS);

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF))   miss_cnt_q  <= miss_cnt_q + 32'd1;
      if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_o  = miss_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign miss_cnt_o  = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_bp_fe_fetch_seq.sv
// Testbench for bp_fe_fetch_seq: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the sequencer.
module tb_bp_fe_fetch_seq;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_MISS = 2;
  localparam int M_HALT = 3;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rv = 1'b0;
  logic [63:0] rpc = '0;
  logic [63:0] npc = '0;
  logic        qr = 1'b1;
  logic        icr = 1'b1;
  logic        miss = 1'b0;

  logic        redirect_ready_o, fetch_v_o, fetch_squash_o, misalign_v_o;
  logic [63:0] fetch_pc_o;
  logic [31:0] miss_cnt_o, stall_cnt_o;

  int n_cmp = 0;
  int n_fail = 0;

  // behavioural model state
  int          m_mode;
  logic [63:0] m_pc, m_ipc;
  bit          m_iv, m_mis;
  longint      m_miss_cnt, m_stall_cnt;
  bit          exp_fv, exp_rdy, exp_sq;

  bp_fe_fetch_seq #(.eaddr_width_p(64), .bp_first_pc_p(64'h8000_0000)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .redirect_v_i(rv), .redirect_pc_i(rpc), .redirect_ready_o(redirect_ready_o),
    .next_pc_i(npc), .queue_ready_i(qr), .icache_ready_i(icr), .icache_miss_i(miss),
    .fetch_v_o(fetch_v_o), .fetch_pc_o(fetch_pc_o), .fetch_squash_o(fetch_squash_o),
    .misalign_v_o(misalign_v_o), .miss_cnt_o(miss_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(longint v);
`ifdef BP_FE_FETCH_SEQ_PERF_EN
    return v[31:0];
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 64'h8000_0000; m_ipc = '0; m_iv = 0; m_mis = 0;
    m_miss_cnt = 0; m_stall_cnt = 0;
  endtask

  // Expected combinational outputs for the current model state and inputs.
  task automatic model_eval();
    exp_rdy = (m_mode != M_BOOT);
    exp_fv  = (m_mode == M_RUN) && qr && !miss && !rv;
    if (rv && exp_rdy) exp_sq = m_iv;
    else               exp_sq = (m_mode == M_RUN) && miss && m_iv;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit acc, bad, hit, iss;
    int nxt;
    model_eval();
    acc = rv && exp_rdy;
    bad = acc && (rpc[1:0] != 2'b00);
    hit = (m_mode == M_RUN) && miss && m_iv;
    iss = exp_fv && icr;
    nxt = m_mode;
    if ((m_mode == M_RUN && !exp_fv) || m_mode == M_MISS)
      m_stall_cnt = (m_stall_cnt == SAT) ? SAT : m_stall_cnt + 1;
    m_mis = bad;
    if (m_mode == M_BOOT) begin
      nxt = M_RUN; m_iv = 0;
    end else if (acc) begin
      m_iv = 0;
      if (bad) nxt = M_HALT;
      else begin
        m_pc = rpc;
        if (m_mode == M_HALT) nxt = M_RUN;
        else if ((m_mode == M_MISS || miss) && !icr) nxt = M_MISS;
        else nxt = M_RUN;
      end
    end else if (hit) begin
      m_pc = m_ipc; m_iv = 0; nxt = M_MISS;
    end else if (iss) begin
      m_ipc = m_pc; m_pc = npc; m_iv = 1;
    end else begin
      m_iv = 0;
      if (m_mode == M_MISS && icr) nxt = M_RUN;
    end
    if (m_mode == M_RUN && nxt == M_MISS)
      m_miss_cnt = (m_miss_cnt == SAT) ? SAT : m_miss_cnt + 1;
    m_mode = nxt;
  endtask

  // One clock: update model at the edge, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(bit v, logic [63:0] t, logic [63:0] n, bit q, bit c, bit m);
    rv = v; rpc = t; npc = n; qr = q; icr = c; miss = m;
    #2;
    model_eval();
  endtask

  task automatic test_reset();
    drive(1, 64'h40, 64'h44, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_v: got %0b want 0", fetch_v_o); end
    n_cmp++; if (redirect_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", redirect_ready_o); end
    n_cmp++; if (fetch_pc_o !== 64'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want 80000000", fetch_pc_o); end
    n_cmp++; if (misalign_v_o !== 1'b0 || fetch_squash_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got mis=%0b sq=%0b want 0/0", misalign_v_o, fetch_squash_o); end
    n_cmp++; if (miss_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", miss_cnt_o, stall_cnt_o); end
    $display("test_reset done");
  endtask

  task automatic test_boot();
    reset_n = 1'b1;
    drive(0, 0, 64'h8000_0004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b0) begin n_fail++; $display("FAIL boot_no_fetch: got %0b want 0", fetch_v_o); end
    tick();
    drive(0, 0, 64'h8000_0004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h8000_0000) begin n_fail++; $display("FAIL boot_first_fetch: got v=%0b pc=%h want 1/80000000", fetch_v_o, fetch_pc_o); end
    tick();
    $display("test_boot done");
  endtask

  task automatic test_miss_replay();
    logic [31:0] mc0, sc0;
    drive(1, 64'h1000, 64'h0, 1, 1, 0);
    n_cmp++; if (redirect_ready_o !== 1'b1 || fetch_squash_o !== exp_sq) begin n_fail++; $display("FAIL redir_accept: got rdy=%0b sq=%0b want 1/%0b", redirect_ready_o, fetch_squash_o, exp_sq); end
    tick();
    drive(0, 0, 64'h1004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h1000) begin n_fail++; $display("FAIL issue_1000: got v=%0b pc=%h want 1/1000", fetch_v_o, fetch_pc_o); end
    tick();
    mc0 = miss_cnt_o; sc0 = stall_cnt_o;
    drive(0, 0, 64'h1008, 1, 0, 1);
    n_cmp++; if (fetch_squash_o !== 1'b1 || fetch_v_o !== 1'b0) begin n_fail++; $display("FAIL miss_squash: got sq=%0b v=%0b want 1/0", fetch_squash_o, fetch_v_o); end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 64'h1008, 1, 0, 0);
      n_cmp++; if (fetch_v_o !== 1'b0 || fetch_pc_o !== 64'h1000) begin n_fail++; $display("FAIL miss_hold[%0d]: got v=%0b pc=%h want 0/1000", i, fetch_v_o, fetch_pc_o); end
      tick();
    end
    drive(0, 0, 64'h1008, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b0) begin n_fail++; $display("FAIL miss_ready_cycle: got v=%0b want 0", fetch_v_o); end
    tick();
    drive(0, 0, 64'h1100, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h1000) begin n_fail++; $display("FAIL replay_1000: got v=%0b pc=%h want 1/1000", fetch_v_o, fetch_pc_o); end
    n_cmp++; if (miss_cnt_o - mc0 !== exp_cnt(1)) begin n_fail++; $display("FAIL miss_count_delta: got %0d want %0d", miss_cnt_o - mc0, exp_cnt(1)); end
    n_cmp++; if (stall_cnt_o - sc0 !== exp_cnt(7)) begin n_fail++; $display("FAIL stall_count_delta: got %0d want %0d", stall_cnt_o - sc0, exp_cnt(7)); end
    tick();
    $display("test_miss_replay done");
  endtask

  task automatic test_redirect_miss();
    drive(0, 0, 64'h1104, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h1100) begin n_fail++; $display("FAIL pre_issue_1100: got v=%0b pc=%h want 1/1100", fetch_v_o, fetch_pc_o); end
    tick();
    drive(1, 64'h2000, 64'h1108, 1, 0, 1);
    n_cmp++; if (fetch_squash_o !== 1'b1 || redirect_ready_o !== 1'b1) begin n_fail++; $display("FAIL redir_miss_squash: got sq=%0b rdy=%0b want 1/1", fetch_squash_o, redirect_ready_o); end
    tick();
    drive(0, 0, 64'h2004, 1, 0, 0);
    n_cmp++; if (fetch_pc_o !== 64'h2000 || fetch_v_o !== 1'b0) begin n_fail++; $display("FAIL redir_miss_state: got pc=%h v=%0b want 2000/0", fetch_pc_o, fetch_v_o); end
    tick();
    drive(0, 0, 64'h2004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b0) begin n_fail++; $display("FAIL redir_miss_wait: got v=%0b want 0", fetch_v_o); end
    tick();
    drive(0, 0, 64'h2004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h2000) begin n_fail++; $display("FAIL issue_2000: got v=%0b pc=%h want 1/2000", fetch_v_o, fetch_pc_o); end
    tick();
    $display("test_redirect_miss done");
  endtask

  task automatic test_misalign();
    drive(1, 64'h3002, 64'h2008, 1, 1, 0);
    n_cmp++; if (redirect_ready_o !== 1'b1 || misalign_v_o !== 1'b0) begin n_fail++; $display("FAIL misalign_accept: got rdy=%0b mis=%0b want 1/0", redirect_ready_o, misalign_v_o); end
    tick();
    drive(0, 0, 64'h2008, 1, 1, 0);
    n_cmp++; if (misalign_v_o !== 1'b1 || fetch_v_o !== 1'b0 || fetch_pc_o !== 64'h2004) begin n_fail++; $display("FAIL misalign_pulse: got mis=%0b v=%0b pc=%h want 1/0/2004", misalign_v_o, fetch_v_o, fetch_pc_o); end
    tick();
    drive(0, 0, 64'h2008, 1, 1, 0);
    n_cmp++; if (misalign_v_o !== 1'b0 || fetch_v_o !== 1'b0) begin n_fail++; $display("FAIL halt_hold: got mis=%0b v=%0b want 0/0", misalign_v_o, fetch_v_o); end
    tick();
    drive(1, 64'h3000, 64'h2008, 1, 1, 0);
    n_cmp++; if (redirect_ready_o !== 1'b1) begin n_fail++; $display("FAIL halt_ready: got %0b want 1", redirect_ready_o); end
    tick();
    drive(0, 0, 64'h3004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h3000) begin n_fail++; $display("FAIL halt_exit_3000: got v=%0b pc=%h want 1/3000", fetch_v_o, fetch_pc_o); end
    tick();
    $display("test_misalign done");
  endtask

  task automatic test_queue_stall();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 64'h3008, 0, 1, 0);
      n_cmp++; if (fetch_v_o !== 1'b0 || fetch_pc_o !== 64'h3004) begin n_fail++; $display("FAIL queue_hold[%0d]: got v=%0b pc=%h want 0/3004", i, fetch_v_o, fetch_pc_o); end
      tick();
    end
    drive(0, 0, 64'h3008, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h3004) begin n_fail++; $display("FAIL queue_resume: got v=%0b pc=%h want 1/3004", fetch_v_o, fetch_pc_o); end
    tick();
    $display("test_queue_stall done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] t, n;
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      n = {$urandom, $urandom};
      drive($urandom_range(0, 9) == 0, t, n, $urandom_range(0, 4) != 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);
      n_cmp++; if (fetch_v_o !== exp_fv || redirect_ready_o !== exp_rdy || fetch_squash_o !== exp_sq) begin
        n_fail++; bad++;
        $display("FAIL rand_comb[%0d]: got v/rdy/sq=%0b%0b%0b want %0b%0b%0b", i, fetch_v_o, redirect_ready_o, fetch_squash_o, exp_fv, exp_rdy, exp_sq);
      end
      n_cmp++; if (fetch_pc_o !== m_pc || misalign_v_o !== m_mis) begin
        n_fail++; bad++;
        $display("FAIL rand_pc[%0d]: got pc=%h mis=%0b want %h/%0b", i, fetch_pc_o, misalign_v_o, m_pc, m_mis);
      end
      n_cmp++; if (miss_cnt_o !== exp_cnt(m_miss_cnt) || stall_cnt_o !== exp_cnt(m_stall_cnt)) begin
        n_fail++; bad++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, miss_cnt_o, stall_cnt_o, exp_cnt(m_miss_cnt), exp_cnt(m_stall_cnt));
      end
      tick();
    end
    $display("test_random done: %0d bad cycles", bad);
  endtask

  task automatic test_async_reset();
    drive(1, 64'h4000, 64'h0, 1, 1, 0);
    tick();
    drive(0, 0, 64'h4004, 1, 1, 0);
    tick();
    drive(0, 0, 64'h4008, 1, 0, 1);
    tick();
    drive(1, 64'h5000, 64'h4008, 1, 0, 0);
    n_cmp++; if (redirect_ready_o !== 1'b1 || fetch_pc_o !== 64'h4000) begin n_fail++; $display("FAIL pre_reset_miss: got rdy=%0b pc=%h want 1/4000", redirect_ready_o, fetch_pc_o); end
    reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (redirect_ready_o !== 1'b0 || fetch_v_o !== 1'b0 || fetch_squash_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_comb: got rdy=%0b v=%0b sq=%0b want 0/0/0", redirect_ready_o, fetch_v_o, fetch_squash_o); end
    n_cmp++; if (fetch_pc_o !== 64'h8000_0000 || misalign_v_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_pc: got pc=%h mis=%0b want 80000000/0", fetch_pc_o, misalign_v_o); end
    n_cmp++; if (miss_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", miss_cnt_o, stall_cnt_o); end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 0, 64'h8000_0004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b0 || redirect_ready_o !== 1'b0) begin n_fail++; $display("FAIL reboot_idle: got v=%0b rdy=%0b want 0/0", fetch_v_o, redirect_ready_o); end
    tick();
    drive(0, 0, 64'h8000_0004, 1, 1, 0);
    n_cmp++; if (fetch_v_o !== 1'b1 || fetch_pc_o !== 64'h8000_0000) begin n_fail++; $display("FAIL reboot_fetch: got v=%0b pc=%h want 1/80000000", fetch_v_o, fetch_pc_o); end
    tick();
    $display("test_async_reset done");
  endtask

  initial begin
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    test_boot();
    test_miss_replay();
    test_redirect_miss();
    test_misalign();
    test_queue_stall();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
